firebird7_in_gate1_tessent_data_mux_tdr: RTL and testbench

Parametrised successor to the single-group IJTAG data mux. It takes CH channels of W bits each and gives every channel its own IJTAG-controlled select and override data. Both are held in an internal TDR made of a shift stage and an update stage, so no external TDR is needed. The block sits between the gate1 functional datapath and its consumers, and is accessed through the gate1 IJTAG network via a SIB-driven ijtag_sel.

---
 rtl/firebird7_in_gate1_tessent_data_mux_tdr_if.sv | 20 ++
 rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv | 91 +++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr_if.sv
// IJTAG scan-access bundle for the gate1 data mux TDR.
// The network (SIB side) is the master; the TDR is the slave.
interface firebird7_in_gate1_tessent_data_mux_tdr_if;
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
    input  ijtag_so
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
    output ijtag_so
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// Per-channel IJTAG-controlled data mux with an internal shift/update TDR.
// Each channel c owns a (W+1)-bit chain field: select bit at the field base,
// override data directly above it. The functional path is combinational
// through the mux, so it adds no latency.
// Optional build macro: FIREBIRD7_DATA_MUX_PARITY_EN adds a status bit at
// sr[0] that captures the XOR of the whole update stage.
module firebird7_in_gate1_tessent_data_mux_tdr #(
  parameter int CH      = 3,
  parameter int W       = 3,
  parameter bit SEL_RST = 1'b0
) (
  input  logic                                       ijtag_tck,
  input  logic                                       ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_tdr_if.slave   tap,
  input  logic [CH*W-1:0]                            functional_data_in,
  output logic [CH*W-1:0]                            data_out
);

`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int L = CH*(W+1) + OFS;

  logic [L-1:0]    sr;
  logic [L-1:0]    cap_vec;
  logic [CH-1:0]   sel_upd;
  logic [CH*W-1:0] dat_upd;
  logic [CH-1:0]   sel_next;
  logic [CH*W-1:0] dat_next;

  // Capture image: current select state plus live functional data per field.
  always_comb begin
    cap_vec = '0;
    for (int c = 0; c < CH; c++) begin
      cap_vec[c*(W+1)+OFS]        = sel_upd[c];
      cap_vec[c*(W+1)+OFS+1 +: W] = functional_data_in[c*W +: W];
    end
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
    cap_vec[0] = ^{sel_upd, dat_upd};
`endif
  end

  // Update image: unpack the pre-edge shift contents into select/data fields.
  always_comb begin
    sel_next = '0;
    dat_next = '0;
    for (int c = 0; c < CH; c++) begin
      sel_next[c]         = sr[c*(W+1)+OFS];
      dat_next[c*W +: W]  = sr[c*(W+1)+OFS+1 +: W];
    end
  end

  // Shift stage: capture has priority over shift; all held when not selected.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr <= '0;
    end else if (tap.ijtag_sel) begin
      if (tap.ijtag_ce) begin
        sr <= cap_vec;
      end else if (tap.ijtag_se) begin
        sr <= {tap.ijtag_si, sr[L-1:1]};
      end
    end
  end

  // Update stage: loads every channel at once, only on an update pulse.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sel_upd <= {CH{SEL_RST}};
      dat_upd <= '0;
    end else if (tap.ijtag_sel && tap.ijtag_ue) begin
      sel_upd <= sel_next;
      dat_upd <= dat_next;
    end
  end

  // Output mux: override data replaces functional data on selected channels.
  always_comb begin
    data_out = functional_data_in;
    for (int c = 0; c < CH; c++) begin
      if (sel_upd[c]) begin
        data_out[c*W +: W] = dat_upd[c*W +: W];
      end
    end
  end

  assign tap.ijtag_so = sr[0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv
// Directed bench for the gate1 data mux TDR (CH=3, W=3).
// Field image constants are 12-bit (select at bit 4c, data at 4c+1..4c+3);
// with the parity build they sit one bit higher above the status bit.
module tb_firebird7_in_gate1_tessent_data_mux_tdr;
  localparam int CH = 3;
  localparam int W  = 3;
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int L = CH*(W+1) + OFS;

  logic            tck;
  logic            rst_n;
  logic [CH*W-1:0] fdi;
  logic [CH*W-1:0] dout;
  int              checks;
  int              errors;

  firebird7_in_gate1_tessent_data_mux_tdr_if tap_if ();

  firebird7_in_gate1_tessent_data_mux_tdr #(
    .CH(CH), .W(W), .SEL_RST(1'b0)
  ) dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst_n),
    .tap                (tap_if),
    .functional_data_in (fdi),
    .data_out           (dout)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  // Shift a field image in (bit 0 first) while collecting what comes out.
  task automatic shift_vec(input logic [11:0] img, output logic [L-1:0] vout);
    logic [L-1:0] vin;
    vin = L'(img) << OFS;
    tap_if.ijtag_sel = 1'b1;
    tap_if.ijtag_se  = 1'b1;
    for (int i = 0; i < L; i++) begin
      tap_if.ijtag_si = vin[i];
      vout[i] = tap_if.ijtag_so;
      tick();
    end
    tap_if.ijtag_se = 1'b0;
    tap_if.ijtag_si = 1'b0;
  endtask

  task automatic capture();
    tap_if.ijtag_sel = 1'b1;
    tap_if.ijtag_ce  = 1'b1;
    tick();
    tap_if.ijtag_ce  = 1'b0;
  endtask

  task automatic update();
    tap_if.ijtag_sel = 1'b1;
    tap_if.ijtag_ue  = 1'b1;
    tick();
    tap_if.ijtag_ue  = 1'b0;
  endtask

  task automatic test_reset();
    logic [L-1:0] v;
    rst_n = 1'b0;
    fdi = 9'h1A5;
    tap_if.ijtag_sel = 1'b0; tap_if.ijtag_ce = 1'b0; tap_if.ijtag_se = 1'b0;
    tap_if.ijtag_ue  = 1'b0; tap_if.ijtag_si = 1'b0;
    tick(); tick();
    checks++;
    if (dout !== 9'h1A5) begin
      errors++; $display("FAIL reset_data_out got %h want %h", dout, 9'h1A5);
    end
    checks++;
    if (tap_if.ijtag_so !== 1'b0) begin
      errors++; $display("FAIL reset_so got %b want 0", tap_if.ijtag_so);
    end
    #2 rst_n = 1'b1;
    tick();
    capture();
    shift_vec(12'h000, v);
    checks++;
    if (v[L-1:OFS] !== 12'hC8A) begin
      errors++; $display("FAIL reset_capture got %h want %h", v[L-1:OFS], 12'hC8A);
    end
  endtask

  task automatic test_override();
    logic [L-1:0] v;
    shift_vec(12'h0D0, v);
    checks++;
    if (dout !== 9'h1A5) begin
      errors++; $display("FAIL shift_no_glitch got %h want %h", dout, 9'h1A5);
    end
    update();
    checks++;
    if (dout !== 9'h1B5) begin
      errors++; $display("FAIL override_ch1 got %h want %h", dout, 9'h1B5);
    end
  endtask

  task automatic test_capture_readout();
    logic [L-1:0] v;
    fdi = 9'h0F3;
    #1;
    checks++;
    if (dout !== 9'h0F3) begin
      errors++; $display("FAIL override_f3 got %h want %h", dout, 9'h0F3);
    end
    capture();
    shift_vec(12'h000, v);
    checks++;
    if (v[L-1:OFS] !== 12'h6D6) begin
      errors++; $display("FAIL capture_readout got %h want %h", v[L-1:OFS], 12'h6D6);
    end
  endtask

  task automatic test_priority();
    logic [L-1:0] v;
    fdi = 9'h1A5;
    tap_if.ijtag_sel = 1'b1;
    tap_if.ijtag_ce  = 1'b1;
    tap_if.ijtag_se  = 1'b1;
    tap_if.ijtag_si  = 1'b1;
    tick();
    tap_if.ijtag_ce = 1'b0; tap_if.ijtag_se = 1'b0; tap_if.ijtag_si = 1'b0;
    // deselected edge with ce/se active must leave sr untouched
    fdi = 9'h000;
    tap_if.ijtag_sel = 1'b0;
    tap_if.ijtag_ce  = 1'b1;
    tap_if.ijtag_se  = 1'b1;
    tick();
    tap_if.ijtag_ce = 1'b0; tap_if.ijtag_se = 1'b0;
    fdi = 9'h1A5;
    shift_vec(12'h000, v);
    checks++;
    if (v[L-1:OFS] !== 12'hC9A) begin
      errors++; $display("FAIL ce_se_priority got %h want %h", v[L-1:OFS], 12'hC9A);
    end
    tap_if.ijtag_sel = 1'b0;
    tap_if.ijtag_ue  = 1'b1;
    tick();
    tap_if.ijtag_ue  = 1'b0;
    checks++;
    if (dout !== 9'h1B5) begin
      errors++; $display("FAIL ue_deselected got %h want %h", dout, 9'h1B5);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [L-1:0] vin;
    logic [L-1:0] v;
    vin = L'(12'h0D0) << OFS;
    tap_if.ijtag_sel = 1'b1;
    tap_if.ijtag_se  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tap_if.ijtag_si = vin[i];
      tick();
    end
    tap_if.ijtag_se = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 9'h1A5) begin
      errors++; $display("FAIL midshift_reset_out got %h want %h", dout, 9'h1A5);
    end
    checks++;
    if (tap_if.ijtag_so !== 1'b0) begin
      errors++; $display("FAIL midshift_reset_so got %b want 0", tap_if.ijtag_so);
    end
    #1 rst_n = 1'b1;
    tick();
    capture();
    shift_vec(12'h000, v);
    checks++;
    if (v[L-1:OFS] !== 12'hC8A) begin
      errors++; $display("FAIL midshift_reset_capture got %h want %h", v[L-1:OFS], 12'hC8A);
    end
  endtask

`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
  task automatic test_parity();
    logic [L-1:0] v;
    shift_vec(12'h00F, v);
    update();
    capture();
    shift_vec(12'h000, v);
    checks++;
    if (v[0] !== 1'b0) begin
      errors++; $display("FAIL parity_even got %b want 0", v[0]);
    end
    shift_vec(12'h01F, v);
    update();
    capture();
    shift_vec(12'h000, v);
    checks++;
    if (v[0] !== 1'b1) begin
      errors++; $display("FAIL parity_odd got %b want 1", v[0]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_override();
    test_capture_readout();
    test_priority();
    test_reset_mid_shift();
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
